// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared y86 constants and memory arbiter state encoding
package y86_pkg;

  localparam logic [3:0] SAOK = 4'b0001;
  localparam logic [3:0] SHLT = 4'b0010;
  localparam logic [3:0] SADR = 4'b0100;
  localparam logic [3:0] SINS = 4'b1000;

  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IJXX    = 4'h7;

  localparam int FETCH_BYTES = 10;
  localparam int DATA_BYTES  = 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FETCH = 2'd1,
    ARB_DATA  = 2'd2,
    ARB_DRAIN = 2'd3
  } arb_state_e;

endpackage

// File: rtl/arb_range_chk.sv
// rtl/arb_range_chk.sv - address plus access length versus memory size fault check
module arb_range_chk #(
  parameter int ADDR_W    = 64,
  parameter int MEM_BYTES = 8192,
  parameter int LEN       = 8
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              fault_o
);

  // One extra bit so an address that wraps past the top still reads as out of range.
  logic [ADDR_W:0] end_addr;

  assign end_addr = {1'b0, addr_i} + (ADDR_W+1)'(LEN);
  assign fault_o  = end_addr > (ADDR_W+1)'(MEM_BYTES);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data, data first
module mem_port_arbiter
  import y86_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int MEM_BYTES = 8192
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              flush,
  output logic              f_valid,
  output logic [79:0]       f_rdata,
  output logic              f_err,
  input  logic              m_req,
  input  logic              m_we,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [63:0]       m_wdata,
  output logic              m_valid,
  output logic [63:0]       m_rdata,
  output logic              m_err,
  output logic              f_mem_stall,
  output logic              m_mem_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [79:0]       mem_rdata,
  input  logic              mem_err
);

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [63:0]       mem_wdata_q, mem_wdata_d;
  logic              f_valid_q, f_valid_d;
  logic [79:0]       f_rdata_q, f_rdata_d;
  logic              f_err_q, f_err_d;
  logic              m_valid_q, m_valid_d;
  logic [63:0]       m_rdata_q, m_rdata_d;
  logic              m_err_q, m_err_d;

  logic f_fault, m_fault, ack, grant_en, m_cand, f_cand;

  arb_range_chk #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES), .LEN(FETCH_BYTES)) u_f_chk (
    .addr_i (f_addr),
    .fault_o(f_fault)
  );

  arb_range_chk #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES), .LEN(DATA_BYTES)) u_m_chk (
    .addr_i (m_addr),
    .fault_o(m_fault)
  );

  assign ack      = mem_ack & (state_q != ARB_IDLE);
  assign grant_en = (state_q == ARB_IDLE) | ack;
  // A port completing now or pulsing valid still holds its request; don't reissue it.
  assign m_cand   = m_req & ~m_valid_q & ~(ack & (state_q == ARB_DATA));
  assign f_cand   = f_req & ~flush & ~f_valid_q & ~(ack & (state_q == ARB_FETCH));

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    f_valid_d   = 1'b0;
    f_rdata_d   = f_rdata_q;
    f_err_d     = f_err_q;
    m_valid_d   = 1'b0;
    m_rdata_d   = m_rdata_q;
    m_err_d     = m_err_q;

    if (ack) begin
      state_d     = ARB_IDLE;
      mem_req_d   = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      if (state_q == ARB_FETCH && !flush) begin
        f_valid_d = 1'b1;
        f_rdata_d = mem_rdata;
        f_err_d   = mem_err;
      end
      if (state_q == ARB_DATA) begin
        m_valid_d = 1'b1;
        m_err_d   = mem_err;
        m_rdata_d = (mem_we_q || mem_err) ? 64'd0 : mem_rdata[63:0];
      end
    end else if (state_q == ARB_FETCH && flush) begin
      state_d = ARB_DRAIN;
    end

    if (grant_en) begin
      if (m_cand) begin
        if (m_fault) begin
          m_valid_d = 1'b1;
          m_err_d   = 1'b1;
          m_rdata_d = '0;
        end else begin
          state_d     = ARB_DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = m_we;
          mem_addr_d  = m_addr;
          mem_wdata_d = m_wdata;
        end
      end else if (f_cand) begin
        if (f_fault) begin
          f_valid_d = 1'b1;
          f_err_d   = 1'b1;
          f_rdata_d = '0;
        end else begin
          state_d     = ARB_FETCH;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = f_addr;
          mem_wdata_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      f_valid_q   <= 1'b0;
      f_rdata_q   <= '0;
      f_err_q     <= 1'b0;
      m_valid_q   <= 1'b0;
      m_rdata_q   <= '0;
      m_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      f_valid_q   <= f_valid_d;
      f_rdata_q   <= f_rdata_d;
      f_err_q     <= f_err_d;
      m_valid_q   <= m_valid_d;
      m_rdata_q   <= m_rdata_d;
      m_err_q     <= m_err_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign f_valid     = f_valid_q;
  assign f_rdata     = f_rdata_q;
  assign f_err       = f_err_q;
  assign m_valid     = m_valid_q;
  assign m_rdata     = m_rdata_q;
  assign m_err       = m_err_q;
  assign f_mem_stall = f_req & ~f_valid_q;
  assign m_mem_stall = m_req & ~m_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized bench for mem_port_arbiter against a byte-array model
module tb_mem_port_arbiter;

  localparam int MEM_BYTES = 8192;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, flush, m_req, m_we;
  logic [63:0] f_addr, m_addr, m_wdata;
  logic        f_valid, f_err, m_valid, m_err, f_mem_stall, m_mem_stall;
  logic [79:0] f_rdata;
  logic [63:0] m_rdata;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [79:0] mem_rdata = '0;
  logic        mem_err = 1'b0;

  mem_port_arbiter #(.ADDR_W(64), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .flush(flush),
    .f_valid(f_valid), .f_rdata(f_rdata), .f_err(f_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_valid(m_valid), .m_rdata(m_rdata), .m_err(m_err),
    .f_mem_stall(f_mem_stall), .m_mem_stall(m_mem_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int stall_bad = 0;
  int n_mem_txn = 0;
  int exp_txn   = 0;
  int lat = 3;
  bit inj_err = 1'b0;
  logic [7:0]  mem_arr [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic [63:0] last_addr;
  logic        last_we;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Memory: acks lat cycles after mem_req rises, back-to-back requests restart the count.
  int          cnt = 0;
  logic [63:0] rise_addr;
  logic [64:0] rise_wd;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ack = 1'b0;
      mem_err = 1'b0;
      cnt = 0;
    end else begin
      #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
        mem_err = 1'b0;
        cnt = 0;
      end
      if (mem_req) begin
        cnt++;
        if (cnt == 1) begin
          rise_addr = mem_addr;
          rise_wd   = {mem_we, mem_wdata};
        end
        if (cnt == lat + 1) begin
          check("mem_hold_addr", 80'(mem_addr), 80'(rise_addr));
          check("mem_hold_wd", 80'({mem_we, mem_wdata}), 80'(rise_wd));
          mem_ack = 1'b1;
          mem_err = inj_err;
          inj_err = 1'b0;
          n_mem_txn++;
          last_addr = mem_addr;
          last_we   = mem_we;
          for (int b = 0; b < 10; b++)
            mem_rdata[b*8 +: 8] = (mem_addr + 64'(b) < 64'(MEM_BYTES)) ? mem_arr[int'(mem_addr[12:0]) + b] : 8'h00;
          if (mem_we)
            for (int b = 0; b < 8; b++) mem_arr[int'(mem_addr[12:0]) + b] = mem_wdata[b*8 +: 8];
        end
      end
    end
  end

  function automatic bit oob(input logic [63:0] a, input int len);
    logic [64:0] e;
    e = {1'b0, a} + 65'(len);
    return e > 65'(MEM_BYTES);
  endfunction

  // Caller is aligned just after a rising edge.
  task automatic do_fetch(input logic [63:0] a, output int cyc);
    bit got; bit flt; logic [79:0] exp_d;
    flt = oob(a, 10);
    if (!flt) exp_txn++;
    f_addr = a; f_req = 1'b1;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      if (f_valid) got = 1'b1;
      else begin
        if (!f_mem_stall) stall_bad++;
        @(posedge clk); #1; cyc++;
      end
    end
    if (got) begin
      exp_d = '0;
      if (!flt) for (int b = 0; b < 10; b++) exp_d[b*8 +: 8] = ref_mem[int'(a[12:0]) + b];
      check("f_err", 80'(f_err), 80'(flt));
      check("f_rdata", f_rdata, exp_d);
      if (f_mem_stall) stall_bad++;
      @(posedge clk); #1;
    end else check("f_timeout", 80'(0), 80'(1));
    f_req = 1'b0;
  endtask

  task automatic do_data(input bit we, input logic [63:0] a, input logic [63:0] wd,
                         input bit exp_merr, output int cyc);
    bit got; bit flt; bit e; logic [63:0] exp_d;
    flt = oob(a, 8);
    if (!flt) exp_txn++;
    m_we = we; m_addr = a; m_wdata = wd; m_req = 1'b1;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      if (m_valid) got = 1'b1;
      else begin
        if (!m_mem_stall) stall_bad++;
        @(posedge clk); #1; cyc++;
      end
    end
    if (got) begin
      e = flt | exp_merr;
      exp_d = '0;
      if (!e && !we) for (int b = 0; b < 8; b++) exp_d[b*8 +: 8] = ref_mem[int'(a[12:0]) + b];
      check("m_err", 80'(m_err), 80'(e));
      check("m_rdata", 80'(m_rdata), 80'(exp_d));
      if (!e && we) for (int b = 0; b < 8; b++) ref_mem[int'(a[12:0]) + b] = wd[b*8 +: 8];
      if (m_mem_stall) stall_bad++;
      @(posedge clk); #1;
    end else check("m_timeout", 80'(0), 80'(1));
    m_req = 1'b0;
  endtask

  int l1, l2, cyc, seen, img_bad, r, mode;
  logic [63:0] fa, da, wd;
  bit we, ie;

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) begin
      mem_arr[i] = 8'($urandom);
      ref_mem[i] = mem_arr[i];
    end
    rst_n = 1'b0; f_req = 0; flush = 0; m_req = 0; m_we = 0;
    f_addr = '0; m_addr = '0; m_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 80'({mem_req, mem_we, f_valid, f_err, m_valid, m_err, f_mem_stall, m_mem_stall}), 80'(0));
    check("rst_data", 80'(mem_addr | mem_wdata | m_rdata), 80'(0));
    rst_n = 1'b1;

    // Directed fetch at 0x100, memory latency 3.
    lat = 3;
    @(posedge clk); #1;
    do_fetch(64'h100, l1);
    check("fetch_lat", 80'(l1), 80'(5));
    check("fetch_addr", 80'({last_we, last_addr}), 80'(64'h100));

    // Store and fetch together: store first, fetch granted in the store ack cycle.
    @(posedge clk); #1;
    fork
      do_data(1'b1, 64'h200, 64'hDEADBEEF, 1'b0, l2);
      do_fetch(64'h100, l1);
    join
    check("pair_data_lat", 80'(l2), 80'(5));
    check("pair_fetch_lat", 80'(l1), 80'(9));
    @(posedge clk); #1;
    do_data(1'b0, 64'h200, 64'h0, 1'b0, l2);

    // Flush one cycle after the fetch grant, redirect to 0x40.
    @(posedge clk); #1;
    exp_txn += 2;
    f_req = 1'b1; f_addr = 64'h300;
    @(posedge clk); #1;
    flush = 1'b1; f_addr = 64'h40;
    @(posedge clk); #1;
    flush = 1'b0;
    cyc = 2; seen = 0;
    while (seen == 0 && cyc < 100) begin
      @(negedge clk);
      if (f_valid) seen = 1;
      else begin @(posedge clk); #1; cyc++; end
    end
    check("flush_lat", 80'(cyc), 80'(9));
    check("flush_addr", 80'(last_addr), 80'(64'h40));
    begin
      logic [79:0] e40;
      for (int b = 0; b < 10; b++) e40[b*8 +: 8] = ref_mem[64 + b];
      check("flush_rdata", f_rdata, e40);
    end
    @(posedge clk); #1; f_req = 1'b0;

    // Range faults, including the wrap case and exact-fit boundaries.
    @(posedge clk); #1;
    do_data(1'b0, 64'(MEM_BYTES - 4), 64'h0, 1'b0, l2);
    check("oob_lat", 80'(l2), 80'(1));
    @(posedge clk); #1;
    do_data(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b0, l2);
    @(posedge clk); #1;
    do_data(1'b0, 64'(MEM_BYTES - 8), 64'h0, 1'b0, l2);
    @(posedge clk); #1;
    do_fetch(64'(MEM_BYTES - 9), l1);
    @(posedge clk); #1;
    do_fetch(64'(MEM_BYTES - 10), l1);

    // Memory error on a load.
    @(posedge clk); #1;
    inj_err = 1'b1;
    do_data(1'b0, 64'h1800, 64'h0, 1'b1, l2);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      lat  = $urandom_range(1, 4);
      mode = $urandom_range(0, 2);
      r    = $urandom_range(0, 9);
      fa   = (r == 0) ? 64'(MEM_BYTES - 9) : (r == 1) ? 64'hFFFF_FFFF_FFFF_FFFA : 64'($urandom_range(0, 4000));
      r    = $urandom_range(0, 9);
      da   = (r == 0) ? 64'(MEM_BYTES - 7) : (r == 1) ? 64'(MEM_BYTES - 8) :
             (r == 2) ? {$urandom, $urandom} : 64'($urandom_range(4096, MEM_BYTES - 8));
      we   = 1'($urandom);
      wd   = {$urandom, $urandom};
      ie   = (mode == 1) && !we && !oob(da, 8) && ($urandom_range(0, 3) == 0);
      inj_err = ie;
      @(posedge clk); #1;
      case (mode)
        0: do_fetch(fa, l1);
        1: do_data(we, da, wd, ie, l2);
        default: fork
          do_fetch(fa, l1);
          do_data(we, da, wd, 1'b0, l2);
        join
      endcase
      inj_err = 1'b0;
    end

    // Asynchronous reset in the middle of a load.
    lat = 3;
    @(posedge clk); #1;
    m_we = 1'b0; m_addr = 64'h1000; m_req = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_ctrl", 80'({mem_req, mem_we, f_valid, f_err, m_valid, m_err}), 80'(0));
    check("arst_data", 80'(mem_addr | m_rdata | f_rdata[63:0]), 80'(0));
    m_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (m_valid || mem_req) seen++;
    end
    check("arst_quiet", 80'(seen), 80'(0));

    img_bad = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (mem_arr[i] !== ref_mem[i]) img_bad++;
    check("mem_image", 80'(img_bad), 80'(0));
    check("stall", 80'(stall_bad), 80'(0));
    check("txn_count", 80'(n_mem_txn), 80'(exp_txn));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
